// File: rtl/execute_unit.sv
`default_nettype none
// ============================================================================
//  Module      : execute_unit
//  Description : Execute stage behind the 8x16 register file. Single-cycle
//                ALU operations plus a WIDTH-cycle iterative shift-add
//                multiply. Results are returned to the register file through
//                a one-cycle write strobe with address and data.
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_unit #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  start,
    input  logic [2:0]            opcode,
    input  logic [WIDTH-1:0]      operandA,
    input  logic [WIDTH-1:0]      operandB,
    input  logic [ADDR_WIDTH-1:0] destAddress,
    output logic                  busy,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] writeAddress,
    output logic [WIDTH-1:0]      writeData,
    output logic                  zeroFlag,
    output logic                  carryFlag
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_WB   = 2'd2;

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SHL = 3'b101;
    localparam logic [2:0] c_OP_SHR = 3'b110;
    localparam logic [2:0] c_OP_MUL = 3'b111;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      count_q;
    logic [WIDTH-1:0]      acc_q;
    logic [WIDTH-1:0]      mcand_q;
    logic [WIDTH-1:0]      mplier_q;
    logic [ADDR_WIDTH-1:0] dest_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [WIDTH-1:0]      wr_data_q;
    logic                  zero_q;
    logic                  carry_q;

    // Combinational helpers
    logic                  w_accept;
    logic                  w_mul_last;
    logic [WIDTH-1:0]      w_acc_next;
    logic [WIDTH-1:0]      w_alu_result;
    logic                  w_alu_carry;
    logic [3:0]            w_shamt;
    logic [WIDTH:0]        w_add_full;
    logic [WIDTH:0]        w_sub_full;
    logic [WIDTH:0]        w_shl_full;
    logic [WIDTH:0]        w_shr_full;

    assign w_accept   = (state_q == c_ST_IDLE) && start;
    assign w_mul_last = (state_q == c_ST_MUL) && (count_q == c_CNT_LAST);
    assign w_shamt    = operandB[3:0];

    // Single-cycle ALU evaluated straight from the live operands; the result
    // is captured on the accepting edge so no operand latch is needed.
    always_comb begin
        w_add_full   = {1'b0, operandA} + {1'b0, operandB};
        w_sub_full   = {1'b0, operandA} - {1'b0, operandB};
        // The extra bit beyond the word catches the last bit shifted out;
        // a zero shift leaves it at 0.
        w_shl_full   = {1'b0, operandA} << w_shamt;
        w_shr_full   = {operandA, 1'b0} >> w_shamt;
        w_alu_result = '0;
        w_alu_carry  = 1'b0;
        case (opcode)
            c_OP_ADD: begin
                w_alu_result = w_add_full[WIDTH-1:0];
                w_alu_carry  = w_add_full[WIDTH];
            end
            c_OP_SUB: begin
                w_alu_result = w_sub_full[WIDTH-1:0];
                w_alu_carry  = w_sub_full[WIDTH];
            end
            c_OP_AND: w_alu_result = operandA & operandB;
            c_OP_OR:  w_alu_result = operandA | operandB;
            c_OP_XOR: w_alu_result = operandA ^ operandB;
            c_OP_SHL: begin
                w_alu_result = w_shl_full[WIDTH-1:0];
                w_alu_carry  = w_shl_full[WIDTH];
            end
            c_OP_SHR: begin
                w_alu_result = w_shr_full[WIDTH:1];
                w_alu_carry  = w_shr_full[0];
            end
            default: begin
                w_alu_result = '0;
                w_alu_carry  = 1'b0;
            end
        endcase
    end

    // One shift-add step: the accumulator value after this cycle's iteration.
    always_comb begin
        w_acc_next = acc_q;
        if (mplier_q[0]) begin
            w_acc_next = acc_q + mcand_q;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (start) begin
                    state_d = (opcode == c_OP_MUL) ? c_ST_MUL : c_ST_WB;
                end
            end
            c_ST_MUL: begin
                if (count_q == c_CNT_LAST) begin
                    state_d = c_ST_WB;
                end
            end
            c_ST_WB:  state_d = c_ST_IDLE;
            default:  state_d = c_ST_IDLE;
        endcase
    end

    // Output logic: busy and the write strobe are pure functions of state.
    always_comb begin
        busy  = (state_q != c_ST_IDLE);
        write = (state_q == c_ST_WB);
    end

    // Multiplier working registers: loaded on accept, stepped while in MUL.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            dest_q   <= '0;
        end else if (w_accept) begin
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= operandA;
            mplier_q <= operandB;
            dest_q   <= destAddress;
        end else if (state_q == c_ST_MUL) begin
            count_q  <= count_q + 1'b1;
            acc_q    <= w_acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    // Result and flag registers: loaded on the edge that enters WB and held
    // otherwise, so writeData/writeAddress keep their last value.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else if (w_accept && (opcode != c_OP_MUL)) begin
            wr_addr_q <= destAddress;
            wr_data_q <= w_alu_result;
            zero_q    <= (w_alu_result == '0);
            carry_q   <= w_alu_carry;
        end else if (w_mul_last) begin
            wr_addr_q <= dest_q;
            wr_data_q <= w_acc_next;
            zero_q    <= (w_acc_next == '0);
            carry_q   <= 1'b0;
        end
    end

    assign writeAddress = wr_addr_q;
    assign writeData    = wr_data_q;
    assign zeroFlag     = zero_q;
    assign carryFlag    = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_unit
//  Description : Self-checking bench for execute_unit. Directed cases plus
//                randomized operations compared against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_unit;

    localparam int WIDTH      = 16;
    localparam int ADDR_WIDTH = 3;

    logic                  clock;
    logic                  resetN;
    logic                  start;
    logic [2:0]            opcode;
    logic [WIDTH-1:0]      operandA;
    logic [WIDTH-1:0]      operandB;
    logic [ADDR_WIDTH-1:0] destAddress;
    logic                  busy;
    logic                  write;
    logic [ADDR_WIDTH-1:0] writeAddress;
    logic [WIDTH-1:0]      writeData;
    logic                  zeroFlag;
    logic                  carryFlag;

    int n_checks = 0;
    int n_errors = 0;

    execute_unit #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clock        (clock),
        .resetN       (resetN),
        .start        (start),
        .opcode       (opcode),
        .operandA     (operandA),
        .operandB     (operandB),
        .destAddress  (destAddress),
        .busy         (busy),
        .write        (write),
        .writeAddress (writeAddress),
        .writeData    (writeData),
        .zeroFlag     (zeroFlag),
        .carryFlag    (carryFlag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {carry, result} from plain arithmetic.
    function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        int unsigned ua, ub, s, r, c;
        logic [15:0] t;
        ua = a; ub = b; s = b[3:0]; r = 0; c = 0;
        case (op)
            3'd0: begin r = (ua + ub) % 65536; c = ((ua + ub) >= 65536) ? 1 : 0; end
            3'd1: begin r = (ua + 65536 - ub) % 65536; c = (ua < ub) ? 1 : 0; end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin
                t = a;
                for (int i = 0; i < s; i++) begin c = t[15]; t = {t[14:0], 1'b0}; end
                r = t;
            end
            3'd6: begin
                t = a;
                for (int i = 0; i < s; i++) begin c = t[0]; t = {1'b0, t[15:1]}; end
                r = t;
            end
            default: begin
                r = 0;
                for (int i = 0; i < 16; i++) if (b[i]) r = (r + (ua << i)) % 65536;
            end
        endcase
        return {c[0], r[15:0]};
    endfunction

    // Issue one operation, wait for its write, check latency, result and flags.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] d, input string tag);
        logic [16:0] exp;
        int cyc;
        exp = model(op, a, b);
        @(negedge clock);
        check_eq({tag, "_idle"}, busy, 1'b0);
        start = 1'b1; opcode = op; operandA = a; operandB = b; destAddress = d;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        // Scramble operand inputs to show the unit works on latched copies.
        operandA = 16'($urandom); operandB = 16'($urandom); opcode = 3'($urandom);
        while (!write && cyc < 40) begin
            @(negedge clock);
            cyc++;
            operandA = 16'($urandom); operandB = 16'($urandom);
        end
        check_eq({tag, "_lat"},   cyc, (op == 3'd7) ? 17 : 1);
        check_eq({tag, "_addr"},  writeAddress, d);
        check_eq({tag, "_data"},  writeData, exp[15:0]);
        check_eq({tag, "_zero"},  zeroFlag, (exp[15:0] == 16'h0));
        check_eq({tag, "_carry"}, carryFlag, exp[16]);
        check_eq({tag, "_busy"},  busy, 1'b1);
        @(negedge clock);
        check_eq({tag, "_wr1"},   write, 1'b0);
        check_eq({tag, "_hold"},  writeData, exp[15:0]);
    endtask

    initial begin
        int wcount;
        logic [15:0] held;
        resetN = 1'b0; start = 1'b0; opcode = 3'd0;
        operandA = '0; operandB = '0; destAddress = '0;
        #12;
        check_eq("rst_busy",  busy, 1'b0);
        check_eq("rst_write", write, 1'b0);
        check_eq("rst_addr",  writeAddress, 3'd0);
        check_eq("rst_data",  writeData, 16'h0);
        check_eq("rst_flags", {zeroFlag, carryFlag}, 2'b00);
        @(negedge clock);
        resetN = 1'b1;

        // Directed cases
        run_op(3'd0, 16'hFFFF, 16'h0001, 3'd3, "add");
        run_op(3'd1, 16'd5,    16'd7,    3'd0, "sub");
        run_op(3'd7, 16'h0123, 16'h0010, 3'd2, "mul");
        run_op(3'd7, 16'h0100, 16'h0100, 3'd5, "mulz");
        run_op(3'd5, 16'h8001, 16'h0001, 3'd1, "shl");
        run_op(3'd6, 16'h8001, 16'h0004, 3'd4, "shr");
        run_op(3'd5, 16'h1234, 16'h0010, 3'd6, "shl0");
        run_op(3'd6, 16'h8001, 16'h000F, 3'd7, "shr15");
        run_op(3'd2, 16'hF0F0, 16'h3C3C, 3'd1, "and");
        run_op(3'd3, 16'hF0F0, 16'h0F0F, 3'd2, "or");
        run_op(3'd4, 16'hAAAA, 16'hAAAA, 3'd3, "xor");

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), "rnd");
        end

        // Busy rejection: an ADD pulsed during a MUL must be dropped.
        @(negedge clock);
        start = 1'b1; opcode = 3'd7; operandA = 16'h0031; operandB = 16'h0203; destAddress = 3'd6;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        start = 1'b1; opcode = 3'd0; operandA = 16'h1111; operandB = 16'h2222; destAddress = 3'd1;
        @(negedge clock);
        start = 1'b0;
        wcount = 0;
        for (int i = 0; i < 25; i++) begin
            if (write) begin
                wcount++;
                check_eq("rej_addr", writeAddress, 3'd6);
                check_eq("rej_data", writeData, model(3'd7, 16'h0031, 16'h0203) & 17'h0FFFF);
            end
            @(negedge clock);
        end
        check_eq("rej_count", wcount, 1);

        // Set flags nonzero, then reset in the middle of a multiply.
        run_op(3'd0, 16'hFFFF, 16'h0001, 3'd3, "pre");
        held = writeData;
        @(negedge clock);
        start = 1'b1; opcode = 3'd7; operandA = 16'h0005; operandB = 16'h0003; destAddress = 3'd2;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check_eq("mid_busy", busy, 1'b1);
        check_eq("mid_hold", writeData, held);
        resetN = 1'b0;
        #1;
        check_eq("arst_busy",  busy, 1'b0);
        check_eq("arst_write", write, 1'b0);
        check_eq("arst_flags", {zeroFlag, carryFlag}, 2'b00);
        check_eq("arst_data",  writeData, 16'h0);
        check_eq("arst_addr",  writeAddress, 3'd0);
        wcount = 0;
        repeat (3) begin
            @(negedge clock);
            if (write) wcount++;
        end
        resetN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (write || busy) wcount++;
        end
        check_eq("arst_nowr", wcount, 0);

        run_op(3'd1, 16'h0000, 16'h0000, 3'd0, "post");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
